// File: rtl/dmem_controller.sv
// Data-memory controller: arbitrates LSU read/write requests from
// NUM_CONSUMERS ports onto NUM_CHANNELS memory channels. Each channel runs
// its own FSM, and a consumer is claimed by at most one channel at a time.
// All outputs come straight from flops.
module dmem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int ID_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAITING,
    S_WRITE_WAITING,
    S_READ_RELAYING,
    S_WRITE_RELAYING
  } state_t;

  // Channel FSM state, the consumer each channel serves, and the claim mask
  state_t                   r_state     [NUM_CHANNELS];
  state_t                   w_state_next[NUM_CHANNELS];
  logic [ID_W-1:0]          r_id        [NUM_CHANNELS];
  logic [ID_W-1:0]          w_id_next   [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] r_claimed;
  logic [NUM_CONSUMERS-1:0] w_claimed_next;
  logic [NUM_CONSUMERS-1:0] w_taken;

  // Arbitration result of each idle channel for this cycle
  logic [NUM_CHANNELS-1:0]  w_pick_valid;
  logic [NUM_CHANNELS-1:0]  w_pick_read;
  logic [ID_W-1:0]          w_pick_id[NUM_CHANNELS];

  // Output registers and their next values
  logic [NUM_CHANNELS-1:0]                 r_mem_read_valid,  w_mem_read_valid_next;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  r_mem_read_address, w_mem_read_address_next;
  logic [NUM_CHANNELS-1:0]                 r_mem_write_valid, w_mem_write_valid_next;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  r_mem_write_address, w_mem_write_address_next;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  r_mem_write_data, w_mem_write_data_next;
  logic [NUM_CONSUMERS-1:0]                r_consumer_read_ready, w_consumer_read_ready_next;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_consumer_read_data, w_consumer_read_data_next;
  logic [NUM_CONSUMERS-1:0]                r_consumer_write_ready, w_consumer_write_ready_next;

  // Unpacked views of the flat buses
  logic [ADDR_BITS-1:0]     w_rd_addr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     w_wr_addr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     w_wr_data [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     w_mem_rd_data[NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] w_wr_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_cons
      assign w_rd_addr[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
      assign w_wr_addr[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
      assign w_wr_data[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
    end
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      assign w_mem_rd_data[gi] = mem_read_data[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  // A read-only build never sees a write request, so the write states are unreachable
  assign w_wr_valid = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

  assign mem_read_valid       = r_mem_read_valid;
  assign mem_read_address     = r_mem_read_address;
  assign mem_write_valid      = r_mem_write_valid;
  assign mem_write_address    = r_mem_write_address;
  assign mem_write_data       = r_mem_write_data;
  assign consumer_read_ready  = r_consumer_read_ready;
  assign consumer_read_data   = r_consumer_read_data;
  assign consumer_write_ready = r_consumer_write_ready;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_state[c] <= S_IDLE;
        r_id[c]    <= '0;
      end
      r_claimed              <= '0;
      r_mem_read_valid       <= '0;
      r_mem_read_address     <= '0;
      r_mem_write_valid      <= '0;
      r_mem_write_address    <= '0;
      r_mem_write_data       <= '0;
      r_consumer_read_ready  <= '0;
      r_consumer_read_data   <= '0;
      r_consumer_write_ready <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_state[c] <= w_state_next[c];
        r_id[c]    <= w_id_next[c];
      end
      r_claimed              <= w_claimed_next;
      r_mem_read_valid       <= w_mem_read_valid_next;
      r_mem_read_address     <= w_mem_read_address_next;
      r_mem_write_valid      <= w_mem_write_valid_next;
      r_mem_write_address    <= w_mem_write_address_next;
      r_mem_write_data       <= w_mem_write_data_next;
      r_consumer_read_ready  <= w_consumer_read_ready_next;
      r_consumer_read_data   <= w_consumer_read_data_next;
      r_consumer_write_ready <= w_consumer_write_ready_next;
    end
  end

  // Next state and claims; channels evaluated in index order so a consumer
  // picked by a lower channel this cycle is invisible to higher ones
  always_comb begin
    w_taken        = r_claimed;
    w_claimed_next = r_claimed;
    w_pick_valid   = '0;
    w_pick_read    = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_state_next[c] = r_state[c];
      w_id_next[c]    = r_id[c];
      w_pick_id[c]    = '0;
      case (r_state[c])
        S_IDLE: begin
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (!w_pick_valid[c] && !w_taken[i] &&
                (consumer_read_valid[i] || w_wr_valid[i])) begin
              w_pick_valid[c] = 1'b1;
              w_pick_read[c]  = consumer_read_valid[i];
              w_pick_id[c]    = ID_W'(i);
            end
          end
          if (w_pick_valid[c]) begin
            w_taken[w_pick_id[c]]        = 1'b1;
            w_claimed_next[w_pick_id[c]] = 1'b1;
            w_id_next[c]                 = w_pick_id[c];
            w_state_next[c] = w_pick_read[c] ? S_READ_WAITING : S_WRITE_WAITING;
          end
        end
        S_READ_WAITING:
          if (mem_read_ready[c]) w_state_next[c] = S_READ_RELAYING;
        S_WRITE_WAITING:
          if (mem_write_ready[c]) w_state_next[c] = S_WRITE_RELAYING;
        S_READ_RELAYING:
          if (!consumer_read_valid[r_id[c]]) begin
            w_state_next[c]          = S_IDLE;
            w_claimed_next[r_id[c]]  = 1'b0;
          end
        S_WRITE_RELAYING:
          if (!w_wr_valid[r_id[c]]) begin
            w_state_next[c]          = S_IDLE;
            w_claimed_next[r_id[c]]  = 1'b0;
          end
        default: w_state_next[c] = S_IDLE;
      endcase
    end
  end

  // Next values of the output registers; anything not touched holds
  always_comb begin
    w_mem_read_valid_next       = r_mem_read_valid;
    w_mem_read_address_next     = r_mem_read_address;
    w_mem_write_valid_next      = r_mem_write_valid;
    w_mem_write_address_next    = r_mem_write_address;
    w_mem_write_data_next       = r_mem_write_data;
    w_consumer_read_ready_next  = r_consumer_read_ready;
    w_consumer_read_data_next   = r_consumer_read_data;
    w_consumer_write_ready_next = r_consumer_write_ready;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (r_state[c])
        S_IDLE:
          if (w_pick_valid[c]) begin
            if (w_pick_read[c]) begin
              w_mem_read_valid_next[c]   = 1'b1;
              w_mem_read_address_next[c] = w_rd_addr[w_pick_id[c]];
            end else begin
              w_mem_write_valid_next[c]   = 1'b1;
              w_mem_write_address_next[c] = w_wr_addr[w_pick_id[c]];
              w_mem_write_data_next[c]    = w_wr_data[w_pick_id[c]];
            end
          end
        S_READ_WAITING:
          if (mem_read_ready[c]) begin
            w_mem_read_valid_next[c]            = 1'b0;
            w_consumer_read_ready_next[r_id[c]] = 1'b1;
            w_consumer_read_data_next[r_id[c]]  = w_mem_rd_data[c];
          end
        S_WRITE_WAITING:
          if (mem_write_ready[c]) begin
            w_mem_write_valid_next[c]            = 1'b0;
            w_consumer_write_ready_next[r_id[c]] = 1'b1;
          end
        S_READ_RELAYING:
          if (!consumer_read_valid[r_id[c]])
            w_consumer_read_ready_next[r_id[c]] = 1'b0;
        S_WRITE_RELAYING:
          if (!w_wr_valid[r_id[c]])
            w_consumer_write_ready_next[r_id[c]] = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Bench for dmem_controller: one 1-channel and one 2-channel instance share
// a memory array. LSU ports 0..3 belong to instance A, 4..7 to instance B;
// memory channel 0 is A's, channels 1..2 are B's. Requests push expected
// responses into a queue; a monitor pops on every consumer-ready rise.
`timescale 1ns/1ps
module tb_dmem_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  lsu_rv, lsu_wv;
  logic [63:0] lsu_ra, lsu_wa, lsu_wd;

  wire  [3:0]  a_rr, a_wr, b_rr, b_wr;
  wire  [31:0] a_rd, b_rd;
  wire         a_mrv, a_mwv;
  wire  [7:0]  a_mra, a_mwa, a_mwd;
  wire  [1:0]  b_mrv, b_mwv;
  wire  [15:0] b_mra, b_mwa, b_mwd;
  logic [2:0]  m_rr, m_wr;
  logic [23:0] m_rdat;

  wire  [7:0]  lsu_rr = {b_rr, a_rr};
  wire  [7:0]  lsu_wr = {b_wr, a_wr};
  wire  [63:0] lsu_rd = {b_rd, a_rd};
  wire  [2:0]  m_rv   = {b_mrv, a_mrv};
  wire  [2:0]  m_wv   = {b_mwv, a_mwv};
  wire  [23:0] m_ra   = {b_mra, a_mra};
  wire  [23:0] m_wa   = {b_mwa, a_mwa};
  wire  [23:0] m_wd   = {b_mwd, a_mwd};

  dmem_controller #(.NUM_CHANNELS(1)) dut_a (
    .clk(clk), .reset(rst),
    .consumer_read_valid(lsu_rv[3:0]), .consumer_read_address(lsu_ra[31:0]),
    .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
    .consumer_write_valid(lsu_wv[3:0]), .consumer_write_address(lsu_wa[31:0]),
    .consumer_write_data(lsu_wd[31:0]), .consumer_write_ready(a_wr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(m_rr[0]), .mem_read_data(m_rdat[7:0]),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa), .mem_write_data(a_mwd),
    .mem_write_ready(m_wr[0])
  );

  dmem_controller #(.NUM_CHANNELS(2)) dut_b (
    .clk(clk), .reset(rst),
    .consumer_read_valid(lsu_rv[7:4]), .consumer_read_address(lsu_ra[63:32]),
    .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
    .consumer_write_valid(lsu_wv[7:4]), .consumer_write_address(lsu_wa[63:32]),
    .consumer_write_data(lsu_wd[63:32]), .consumer_write_ready(b_wr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(m_rr[2:1]), .mem_read_data(m_rdat[23:8]),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa), .mem_write_data(b_mwd),
    .mem_write_ready(m_wr[2:1])
  );

  typedef struct {
    int         port;
    bit         is_wr;
    logic [7:0] data;
    logic [7:0] addr;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp, n_bad;
  int         rd_lat, wr_lat;
  logic [7:0] mem [256];
  bit         pend_rd[8], pend_wr[8], drop_r[8], drop_w[8];
  logic [7:0] prev_rr, prev_wr;
  int         rcnt[3], wcnt[3];
  bit         rserved[3], wserved[3];
  logic [7:0] last_waddr, last_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic pop_check(input int p, input bit w);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_resp: port %0d kind %0d got a response, required none", p, w);
    end else begin
      e = exp_q.pop_front();
      $display("resp port %0d %s data %h (t=%0t)", p, w ? "write" : "read",
               w ? last_wdata : lsu_rd[p*8 +: 8], $time);
      chk("resp_port", p, e.port);
      chk("resp_kind", 32'(w), 32'(e.is_wr));
      if (!w) chk("rd_data", 32'(lsu_rd[p*8 +: 8]), 32'(e.data));
      else begin
        chk("wr_addr", 32'(last_waddr), 32'(e.addr));
        chk("wr_data", 32'(last_wdata), 32'(e.data));
      end
    end
  endtask

  task automatic issue_rd(input int p, input logic [7:0] a, input logic [7:0] d);
    lsu_ra[p*8 +: 8] = a;
    pend_rd[p] = 1'b1;
    exp_q.push_back('{port: p, is_wr: 1'b0, data: d, addr: a});
  endtask

  task automatic issue_wr(input int p, input logic [7:0] a, input logic [7:0] d);
    lsu_wa[p*8 +: 8] = a;
    lsu_wd[p*8 +: 8] = d;
    pend_wr[p] = 1'b1;
    exp_q.push_back('{port: p, is_wr: 1'b1, data: d, addr: a});
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && lsu_rv == 0 && lsu_wv == 0 && lsu_rr == 0 &&
          lsu_wr == 0 && m_rv == 0 && m_wv == 0) ok = 1'b1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  // Monitor, memory responder and LSU models, all on the falling edge
  initial begin
    lsu_rv = '0; lsu_wv = '0; m_rr = '0; m_wr = '0; m_rdat = '0;
    prev_rr = '0; prev_wr = '0; last_waddr = '0; last_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lsu_rv = '0; lsu_wv = '0; m_rr = '0; m_wr = '0;
        prev_rr = '0; prev_wr = '0;
        for (int p = 0; p < 8; p++) begin
          pend_rd[p] = 0; pend_wr[p] = 0; drop_r[p] = 0; drop_w[p] = 0;
        end
        for (int ch = 0; ch < 3; ch++) begin
          rcnt[ch] = 0; wcnt[ch] = 0; rserved[ch] = 0; wserved[ch] = 0;
        end
      end else begin
        for (int p = 0; p < 8; p++) begin
          if (drop_r[p]) begin chk($sformatf("rd_ready_clear[%0d]", p), 32'(lsu_rr[p]), 0); drop_r[p] = 0; end
          if (drop_w[p]) begin chk($sformatf("wr_ready_clear[%0d]", p), 32'(lsu_wr[p]), 0); drop_w[p] = 0; end
          if (lsu_rr[p] && !prev_rr[p]) pop_check(p, 1'b0);
          if (lsu_wr[p] && !prev_wr[p]) pop_check(p, 1'b1);
        end
        prev_rr = lsu_rr;
        prev_wr = lsu_wr;
        for (int ch = 0; ch < 3; ch++) begin
          if (m_rr[ch]) m_rr[ch] = 1'b0;
          else if (m_rv[ch] && !rserved[ch]) begin
            rcnt[ch]++;
            if (rcnt[ch] >= rd_lat) begin
              m_rr[ch] = 1'b1;
              m_rdat[ch*8 +: 8] = mem[m_ra[ch*8 +: 8]];
              rserved[ch] = 1'b1;
              rcnt[ch] = 0;
            end
          end else if (!m_rv[ch]) rserved[ch] = 1'b0;
          if (m_wr[ch]) m_wr[ch] = 1'b0;
          else if (m_wv[ch] && !wserved[ch]) begin
            wcnt[ch]++;
            if (wcnt[ch] >= wr_lat) begin
              m_wr[ch] = 1'b1;
              mem[m_wa[ch*8 +: 8]] = m_wd[ch*8 +: 8];
              last_waddr = m_wa[ch*8 +: 8];
              last_wdata = m_wd[ch*8 +: 8];
              wserved[ch] = 1'b1;
              wcnt[ch] = 0;
            end
          end else if (!m_wv[ch]) wserved[ch] = 1'b0;
        end
        for (int p = 0; p < 8; p++) begin
          if (lsu_rv[p] && lsu_rr[p]) begin lsu_rv[p] = 1'b0; drop_r[p] = 1'b1; end
          else if (pend_rd[p] && !lsu_rv[p] && !lsu_rr[p]) begin lsu_rv[p] = 1'b1; pend_rd[p] = 1'b0; end
          if (lsu_wv[p] && lsu_wr[p]) begin lsu_wv[p] = 1'b0; drop_w[p] = 1'b1; end
          else if (pend_wr[p] && !lsu_wv[p] && !lsu_wr[p]) begin lsu_wv[p] = 1'b1; pend_wr[p] = 1'b0; end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    n_cmp = 0; n_bad = 0;
    rd_lat = 2; wr_lat = 2;
    lsu_ra = '0; lsu_wa = '0; lsu_wd = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h12] = 8'hAB; mem[8'h01] = 8'h11; mem[8'h03] = 8'h33;
    mem[8'h40] = 8'hC0; mem[8'h41] = 8'hC1; mem[8'h42] = 8'hC2; mem[8'h43] = 8'hC3;
    mem[8'h20] = 8'h77; mem[8'h22] = 8'h99;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_flags", {28'd0, a_rr | a_wr}, 0);
    chk("rst_a_mem",   {7'd0, a_mrv, a_mwv, a_mra, a_mwa, a_mwd}, 0);
    chk("rst_a_data",  a_rd, 0);
    chk("rst_b_flags", {20'd0, b_rr, b_wr, b_mrv, b_mwv}, 0);
    chk("rst_b_mem",   {b_mra, b_mwa}, 0);
    chk("rst_b_data",  {b_rd[15:0] | b_rd[31:16], b_mwd}, 0);
    @(posedge clk); #2 rst = 1'b0;

    // Single read: consumer 0, addr 0x12 -> 0xAB
    @(posedge clk); #2 issue_rd(0, 8'h12, 8'hAB);
    @(negedge clk); @(negedge clk);
    chk("t1_mem_rd_valid", 32'(a_mrv), 1);
    chk("t1_mem_rd_addr", 32'(a_mra), 32'h12);
    wait_done("t1_done");

    // Single write: consumer 2 writes 0x55 to 0x30
    @(posedge clk); #2 issue_wr(2, 8'h30, 8'h55);
    @(negedge clk); @(negedge clk);
    chk("t2_mem_wr_valid", 32'(a_mwv), 1);
    chk("t2_mem_wr_addr", 32'(a_mwa), 32'h30);
    chk("t2_mem_wr_data", 32'(a_mwd), 32'h55);
    wait_done("t2_done");

    // Contention on one channel: consumers 1 and 3
    @(posedge clk); #2 issue_rd(1, 8'h01, 8'h11); issue_rd(3, 8'h03, 8'h33);
    @(negedge clk); @(negedge clk);
    chk("t3_first_addr", {31'd0, a_mrv} << 8 | 32'(a_mra), 32'h101);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (a_mrv && a_mra == 8'h03) seen = 1'b1;
    end
    chk("t3_second_issued", 32'(seen), 1);
    chk("t3_c1_released", {30'd0, lsu_rv[1], a_rr[1]}, 0);
    chk("t3_c1_done_first", exp_q.size(), 1);
    wait_done("t3_done");

    // Two channels: consumers 0..3 of instance B in the same cycle
    @(posedge clk); #2
    issue_rd(4, 8'h40, 8'hC0); issue_rd(5, 8'h41, 8'hC1);
    issue_rd(6, 8'h42, 8'hC2); issue_rd(7, 8'h43, 8'hC3);
    @(negedge clk); @(negedge clk);
    chk("t4_both_valid", 32'(b_mrv), 32'h3);
    chk("t4_addrs", 32'(b_mra), 32'h4140);
    wait_done("t4_done");

    // Stalled memory: hold off read ready for 12 cycles
    rd_lat = 12;
    @(posedge clk); #2 issue_rd(0, 8'h20, 8'h77);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t5_hold[%0d]", k), {23'd0, a_mrv, a_mra}, 32'h120);
      chk($sformatf("t5_no_ready[%0d]", k), 32'(a_rr), 0);
    end
    wait_done("t5_done");

    // Reset during READ_WAITING, then a fresh request
    rd_lat = 30;
    @(posedge clk); #2 issue_rd(1, 8'h22, 8'h99);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("t6_waiting", 32'(a_mrv), 1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_flags", {28'd0, a_rr | a_wr}, 0);
    chk("t6_rst_mem", {7'd0, a_mrv, a_mwv, a_mra, a_mwa, a_mwd}, 0);
    chk("t6_rst_data", a_rd, 0);
    exp_q.delete();
    @(posedge clk); #2 rst = 1'b0;
    rd_lat = 2;
    @(posedge clk); #2 issue_rd(1, 8'h22, 8'h99);
    wait_done("t6_done");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
